gcd_unit: RTL and testbench
===========================

Name: gcd_unit

Overview:
- Self-contained, parametrised GCD engine: a subtractive-Euclid datapath and its controlling FSM in one block.
- Accepts an operand pair over a valid/ready input handshake and returns gcd(a, b) over a valid/ready output handshake.
- Successor to the fixed 16-bit GCD datapath; adds configurable width, an internal controller, zero-operand handling and output back-pressure.
- Sits between a producer of operand pairs and a consumer of results.

Parameters:
WIDTH, 16, operand and result width in bits (>= 2)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair on a_in/b_in is valid
in_ready  output  1  block can accept an operand pair
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
out_valid  output  1  result holds a valid GCD
out_ready  input  1  consumer accepts result
result  output  WIDTH  gcd(a, b)
busy  output  1  high in CALC state

Behaviour:
- Reset (async, active-high, asserted at any time, including mid-calculation): state=IDLE, internal a/b registers=0, result=0, out_valid=0, busy=0, in_ready=1. Any in-flight operation is discarded; no result is produced for it.
- States: IDLE, CALC, DONE. All outputs are registered or decoded directly from state:
  - in_ready = (state==IDLE)
  - busy = (state==CALC)
  - out_valid = (state==DONE)
- IDLE: on a rising edge with in_valid && in_ready, load a<=a_in and b<=b_in, then go to CALC. Operands are sampled only on that edge. Input changes at other times are ignored.
- CALC: one step per clock. The priority order is:
  1. If a==0 or b==0: result<=a|b, go to DONE. Covers gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0.
  2. Else if a==b: result<=a, go to DONE.
  3. Else if a>b: a<=a-b.
  4. Else: b<=b-a.
- Arithmetic: unsigned, WIDTH bits. Subtraction is only performed as larger minus smaller, so it never wraps.
- Latency from the accept edge to out_valid high = (number of subtraction steps)+1 cycles.
  - gcd(8,8): 1 cycle.
  - gcd(12,8): 3 cycles.
  - Worst case gcd(2^WIDTH-1, 1): 2^WIDTH-1 cycles.
- DONE: result and out_valid are held stable until out_valid && out_ready on a rising edge, then go to IDLE.
  - out_ready low: stall indefinitely with no change.
  - in_valid is ignored in DONE. The earliest next accept is the cycle after the output handshake.
- Throughput: at most one operation in flight.
- Simultaneous events: reset overrides all. out_ready asserted outside DONE has no effect.
- result retains its last value in IDLE and CALC. Consumers must qualify it with out_valid.

Optional Feature:
- Macro: GCD_CYCLE_COUNT_EN.
- When defined, the block adds an output port cycles (width WIDTH+1).
  - An internal counter clears to 0 on accept and increments once per CALC cycle, including the terminating cycle.
  - cycles presents the latched count in DONE and holds it until the next accept.
  - Reset value is 0.
  - gcd(12,8) gives cycles=3.
- When undefined, the port and counter do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then a_in=12, b_in=8, in_valid=1 for one cycle, out_ready=1 -> out_valid rises 3 cycles after accept, result=4, in_ready=1 the cycle after the handshake; with GCD_CYCLE_COUNT_EN, cycles=3.
2. Zero operands: (0,9) -> result=9 after 1 cycle; (9,0) -> 9; (0,0) -> 0; busy high for exactly 1 cycle each.
3. Back-pressure: a_in=48, b_in=18, out_ready=0 for 10 cycles after out_valid -> result=6 and out_valid held constant; in_valid pulses during the stall are not accepted; release out_ready -> IDLE next cycle.
4. WIDTH=8, a_in=255, b_in=1 -> result=1 after 255 cycles, no wrap.
5. Reset asserted mid-CALC (a_in=1000, b_in=3, 20 cycles in), asynchronous to the clock edge -> outputs immediately return to reset values and no out_valid is produced; a new pair (35,14) afterwards gives result=7.
6. Back-to-back: in_valid held high with pairs (21,6), (17,5), out_ready=1 -> results 3 then 1 in order; each pair is accepted only while in_ready=1.

Source files
------------

// File: rtl/gcd_unit.sv
// gcd_unit: subtractive-Euclid GCD engine with valid/ready operand and result handshakes.
// One operation in flight; IDLE accepts, CALC does one compare/subtract per clock, DONE holds the result.
// Optional build macro GCD_CYCLE_COUNT_EN adds a 'cycles' output reporting CALC cycles used.
module gcd_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [WIDTH:0]   cycles
`endif
);

  localparam int unsigned CNT_W = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;

  logic w_any_zero;
  logic w_equal;
  logic w_a_gt_b;

  // Step decisions for the current operand pair
  assign w_any_zero = (r_a == '0) || (r_b == '0);
  assign w_equal    = (r_a == r_b);
  assign w_a_gt_b   = (r_a > r_b);

  // Handshake and status flags decode straight from the state register
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_CALC);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;

  // Controller and datapath: accept, iterate larger-minus-smaller, hold result until taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (w_any_zero) begin
            r_result <= r_a | r_b;
            r_state  <= S_DONE;
          end else if (w_equal) begin
            r_result <= r_a;
            r_state  <= S_DONE;
          end else if (w_a_gt_b) begin
            r_a <= r_a - r_b;
          end else begin
            r_b <= r_b - r_a;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cycles;

  assign cycles = r_cycles;

  // Cleared on accept, counts every CALC cycle, then holds through DONE and IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycles <= '0;
    end else if ((r_state == S_IDLE) && in_valid) begin
      r_cycles <= '0;
    end else if (r_state == S_CALC) begin
      r_cycles <= r_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Directed bench for gcd_unit: vector table plus hand sequences for stall, reset and back-to-back.
module tb_gcd_unit;

  localparam int LIM = 70000;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        busy;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a_in8;
  logic [7:0]  b_in8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  result8;
  logic        busy8;

`ifdef GCD_CYCLE_COUNT_EN
  logic [16:0] cycles;
  logic [8:0]  cycles8;
`endif

  int n_vec;
  int n_err;

  gcd_unit #(.WIDTH(16)) u_dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles   (cycles)
`endif
  );

  gcd_unit #(.WIDTH(8)) u_dut8 (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid8),
    .in_ready (in_ready8),
    .a_in     (a_in8),
    .b_in     (b_in8),
    .out_valid(out_valid8),
    .out_ready(out_ready8),
    .result   (result8),
    .busy     (busy8)
`ifdef GCD_CYCLE_COUNT_EN
    ,
    .cycles   (cycles8)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Full transaction on the 16-bit instance; hold>0 stalls the consumer for that many cycles
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp,
                       input int el, input int hold);
    int lat;
    int nb;
    @(negedge clock);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    a_in      = a;
    b_in      = b;
    in_valid  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    lat = 0;
    nb  = 0;
    while (!out_valid && lat < LIM) begin
      if (busy) nb++;
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk($sformatf("result(%0d,%0d)", a, b), 32'(result), 32'(exp));
    chk($sformatf("latency(%0d,%0d)", a, b), 32'(lat), 32'(el));
    chk($sformatf("busy_cycles(%0d,%0d)", a, b), 32'(nb), 32'(el));
`ifdef GCD_CYCLE_COUNT_EN
    chk($sformatf("cycles(%0d,%0d)", a, b), 32'(cycles), 32'(el));
`endif
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      a_in     = 16'd5;
      b_in     = 16'd5;
      @(posedge clock);
      @(negedge clock);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_result", 32'(result), 32'(exp));
      chk("stall_busy", 32'(busy), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("in_ready_after_handshake", 32'(in_ready), 32'd1);
    chk("out_valid_after_handshake", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    n_vec = 0;
    n_err = 0;
    reset      = 1'b1;
    in_valid   = 1'b0;
    a_in       = '0;
    b_in       = '0;
    out_ready  = 1'b1;
    in_valid8  = 1'b0;
    a_in8      = '0;
    b_in8      = '0;
    out_ready8 = 1'b1;

    vecs[0]  = '{16'd12,    16'd8,     16'd4,     3, 0};
    vecs[1]  = '{16'd8,     16'd8,     16'd8,     1, 0};
    vecs[2]  = '{16'd0,     16'd9,     16'd9,     1, 0};
    vecs[3]  = '{16'd9,     16'd0,     16'd9,     1, 0};
    vecs[4]  = '{16'd0,     16'd0,     16'd0,     1, 0};
    vecs[5]  = '{16'd48,    16'd18,    16'd6,     5, 10};
    vecs[6]  = '{16'd1,     16'd1,     16'd1,     1, 0};
    vecs[7]  = '{16'd7,     16'd1,     16'd1,     7, 0};
    vecs[8]  = '{16'd1,     16'd7,     16'd1,     7, 0};
    vecs[9]  = '{16'd65535, 16'd65535, 16'd65535, 1, 0};
    vecs[10] = '{16'd100,   16'd75,    16'd25,    4, 0};
    vecs[11] = '{16'd13,    16'd5,     16'd1,     6, 0};
    vecs[12] = '{16'd32768, 16'd16384, 16'd16384, 2, 0};

    #3;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].hold);
    end

    // 8-bit worst case: 254 subtractions plus the terminating step, no wrap
    @(negedge clock);
    a_in8     = 8'd255;
    b_in8     = 8'd1;
    in_valid8 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < LIM) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk("w8_result(255,1)", 32'(result8), 32'd1);
    chk("w8_latency(255,1)", 32'(lat), 32'd255);
`ifdef GCD_CYCLE_COUNT_EN
    chk("w8_cycles(255,1)", 32'(cycles8), 32'd255);
`endif
    @(posedge clock);
    @(negedge clock);
    chk("w8_in_ready_after", 32'(in_ready8), 32'd1);

    // Reset mid-calculation, asserted between clock edges
    a_in     = 16'd1000;
    b_in     = 16'd3;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (20) @(posedge clock);
    #2;
    chk("midcalc_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_busy", 32'(busy), 32'd0);
    chk("async_reset_in_ready", 32'(in_ready), 32'd1);
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    chk("async_reset_result", 32'(result), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("post_reset_no_out_valid", 32'(out_valid), 32'd0);
      chk("post_reset_idle", 32'(busy), 32'd0);
    end
    do_op(16'd35, 16'd14, 16'd7, 4, 0);

    // Back-to-back with in_valid held high
    @(negedge clock);
    chk("b2b_in_ready_1", 32'(in_ready), 32'd1);
    a_in     = 16'd21;
    b_in     = 16'd6;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    a_in = 16'd17;
    b_in = 16'd5;
    chk("b2b_busy_1", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < LIM) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk("b2b_result_1", 32'(result), 32'd3);
    chk("b2b_latency_1", 32'(lat), 32'd5);
    @(posedge clock);
    @(negedge clock);
    chk("b2b_in_ready_2", 32'(in_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    chk("b2b_busy_2", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < LIM) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk("b2b_result_2", 32'(result), 32'd1);
    chk("b2b_latency_2", 32'(lat), 32'd7);
    @(posedge clock);
    @(negedge clock);
    chk("b2b_in_ready_end", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
